car_alarm_controller: RTL and testbench

CAR_ALARM_CONTROLLER -- requirements
Module: car_alarm_controller

---
 rtl/car_alarm_pkg.sv | 15 +
 rtl/alarm_timer.sv | 34 +++
 rtl/car_alarm_controller.sv | 173 +++++++++++++++++
 tb/tb_car_alarm_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/car_alarm_pkg.sv
// Shared state encoding and counter width for the car alarm controller.
// Optional panic input is enabled by defining CAR_ALARM_PANIC_EN.
package car_alarm_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      ST_DISARMED = 3'd0,
      ST_ARMING   = 3'd1,
      ST_ARMED    = 3'd2,
      ST_ENTRY    = 3'd3,
      ST_ALARM    = 3'd4
   } state_e;

endpackage

// File: rtl/alarm_timer.sv
// Loadable down-counter shared by all timed alarm states; holds at zero.
module alarm_timer
   import car_alarm_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/car_alarm_controller.sv
// Car alarm FSM with exit/entry delays, siren timer and hazard flasher.
// Define CAR_ALARM_PANIC_EN to add the panic_req input.
module car_alarm_controller
   import car_alarm_pkg::*;
#(
   parameter int EXIT_DLY   = 16,
   parameter int ENTRY_DLY  = 16,
   parameter int SIREN_LEN  = 64,
   parameter int FLASH_HALF = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       arm_req,
   input  logic       disarm_req,
   input  logic       door_open,
   input  logic       ignition_on,
   input  logic       lights_on,
`ifdef CAR_ALARM_PANIC_EN
   input  logic       panic_req,
`endif
   output logic       siren,
   output logic       lights_flash,
   output logic       armed,
   output logic       lights_warn,
   output logic [2:0] state_o
);

   localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_DLY - 1);
   localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_DLY - 1);
   localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_LEN - 1);
   localparam logic [CNT_W-1:0] FLASH_LD = CNT_W'(FLASH_HALF - 1);

   state_e           state_q, state_d;
   logic             ld, dec, tmr_zero;
   logic [CNT_W-1:0] ld_val;
   logic [CNT_W-1:0] div_q, div_d;
   logic             ph_q, ph_d;
   logic             siren_q, flash_q, armed_q, warn_q;
`ifdef CAR_ALARM_PANIC_EN
   logic             from_dis_q, from_dis_d;
`endif

   alarm_timer u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (ld),
      .load_val_i(ld_val),
      .dec_i     (dec),
      .zero_o    (tmr_zero)
   );

   assign dec = (state_q == ST_ARMING) || (state_q == ST_ENTRY) || (state_q == ST_ALARM);

   // Disarm outranks everything; panic (when built in) outranks the normal flow.
   always_comb begin
      state_d = state_q;
      ld      = 1'b0;
      ld_val  = '0;
`ifdef CAR_ALARM_PANIC_EN
      from_dis_d = from_dis_q;
`endif
      if (disarm_req) begin
         state_d = ST_DISARMED;
`ifdef CAR_ALARM_PANIC_EN
         from_dis_d = 1'b0;
      end else if (panic_req) begin
         state_d = ST_ALARM;
         ld      = 1'b1;
         ld_val  = SIREN_LD;
         if (state_q != ST_ALARM) from_dis_d = (state_q == ST_DISARMED);
`endif
      end else begin
         case (state_q)
            ST_DISARMED: begin
               if (arm_req && !ignition_on) begin
                  state_d = ST_ARMING;
                  ld      = 1'b1;
                  ld_val  = EXIT_LD;
               end
            end
            ST_ARMING: begin
               if (door_open) begin
                  ld     = 1'b1;
                  ld_val = EXIT_LD;
               end else if (tmr_zero) begin
                  state_d = ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (ignition_on) begin
                  state_d = ST_ALARM;
                  ld      = 1'b1;
                  ld_val  = SIREN_LD;
               end else if (door_open) begin
                  state_d = ST_ENTRY;
                  ld      = 1'b1;
                  ld_val  = ENTRY_LD;
               end
            end
            ST_ENTRY: begin
               if (ignition_on || tmr_zero) begin
                  state_d = ST_ALARM;
                  ld      = 1'b1;
                  ld_val  = SIREN_LD;
               end
            end
            ST_ALARM: begin
               if (tmr_zero) begin
`ifdef CAR_ALARM_PANIC_EN
                  state_d    = from_dis_q ? ST_DISARMED : ST_ARMED;
                  from_dis_d = 1'b0;
`else
                  state_d = ST_ARMED;
`endif
               end
            end
            default: state_d = ST_DISARMED;
         endcase
      end
   end

   // Flash phase restarts on every ALARM entry so the first lit half is full length.
   always_comb begin
      div_d = '0;
      ph_d  = 1'b0;
      if (state_q == ST_ALARM) begin
         if (div_q == FLASH_LD) begin
            div_d = '0;
            ph_d  = ~ph_q;
         end else begin
            div_d = div_q + CNT_W'(1);
            ph_d  = ph_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_DISARMED;
         div_q   <= '0;
         ph_q    <= 1'b0;
         siren_q <= 1'b0;
         flash_q <= 1'b0;
         armed_q <= 1'b0;
         warn_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         ph_q    <= ph_d;
         siren_q <= (state_q == ST_ALARM);
         flash_q <= (state_q == ST_ALARM) && !ph_q;
         armed_q <= (state_q == ST_ARMED) || (state_q == ST_ENTRY);
         warn_q  <= lights_on && door_open && !ignition_on;
      end
   end

`ifdef CAR_ALARM_PANIC_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         from_dis_q <= 1'b0;
      end else begin
         from_dis_q <= from_dis_d;
      end
   end
`endif

   assign siren        = siren_q;
   assign lights_flash = flash_q;
   assign armed        = armed_q;
   assign lights_warn  = warn_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_car_alarm_controller.sv
// Bench for car_alarm_controller: directed scenarios plus randomized traffic
// against a cycle-level behavioural model.
module tb_car_alarm_controller;

   localparam int EXIT_DLY   = 4;
   localparam int ENTRY_DLY  = 3;
   localparam int SIREN_LEN  = 8;
   localparam int FLASH_HALF = 2;

   logic       clk         = 1'b0;
   logic       rst_n       = 1'b1;
   logic       arm_req     = 1'b0;
   logic       disarm_req  = 1'b0;
   logic       door_open   = 1'b0;
   logic       ignition_on = 1'b0;
   logic       lights_on   = 1'b0;
   logic       siren, lights_flash, armed, lights_warn;
   logic [2:0] state_o;

   int n_chk  = 0;
   int n_fail = 0;

   // Model: mode (0 disarmed,1 arming,2 armed,3 entry,4 alarm), cycles left in a
   // timed mode, cycles elapsed in alarm, and the expected registered outputs.
   int   md = 0, left = 0, el = 0;
   logic e_siren = 1'b0, e_flash = 1'b0, e_armed = 1'b0, e_warn = 1'b0;

   logic pat [8];

   car_alarm_controller #(
      .EXIT_DLY  (EXIT_DLY),
      .ENTRY_DLY (ENTRY_DLY),
      .SIREN_LEN (SIREN_LEN),
      .FLASH_HALF(FLASH_HALF)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .arm_req     (arm_req),
      .disarm_req  (disarm_req),
      .door_open   (door_open),
      .ignition_on (ignition_on),
      .lights_on   (lights_on),
      .siren       (siren),
      .lights_flash(lights_flash),
      .armed       (armed),
      .lights_warn (lights_warn),
      .state_o     (state_o)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
      end
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      int nm, nl;
      if (!rst_n) begin
         md = 0; left = 0; el = 0;
         e_siren = 1'b0; e_flash = 1'b0; e_armed = 1'b0; e_warn = 1'b0;
      end else begin
         e_siren = (md == 4);
         e_flash = (md == 4) && (((el / FLASH_HALF) % 2) == 0);
         e_armed = (md == 2) || (md == 3);
         e_warn  = lights_on && door_open && !ignition_on;
         nm = md;
         nl = left - 1;
         if (disarm_req) nm = 0;
         else begin
            case (md)
               0: if (arm_req && !ignition_on) begin nm = 1; nl = EXIT_DLY; end
               1: if (door_open) nl = EXIT_DLY; else if (left == 1) nm = 2;
               2: if (ignition_on) begin nm = 4; nl = SIREN_LEN; end
                  else if (door_open) begin nm = 3; nl = ENTRY_DLY; end
               3: if (ignition_on || left == 1) begin nm = 4; nl = SIREN_LEN; end
               4: if (left == 1) nm = 2;
               default: nm = 0;
            endcase
         end
         el   = (md == 4 && nm == 4) ? el + 1 : 0;
         md   = nm;
         left = nl;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_siren", siren, 0);
         check("rst_flash", lights_flash, 0);
         check("rst_armed", armed, 0);
         check("rst_warn", lights_warn, 0);
         check("rst_state", state_o, 0);
      end else begin
         check("mdl_siren", siren, e_siren);
         check("mdl_flash", lights_flash, e_flash);
         check("mdl_armed", armed, e_armed);
         check("mdl_warn", lights_warn, e_warn);
         check("mdl_state", state_o, md);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("init_state", state_o, 0);
      check("init_siren", siren, 0);
      rst_n = 1'b1;

      // Arm immediately after reset release, doors closed
      arm_req = 1'b1; tick(); arm_req = 1'b0;
      check("arm_c1_state", state_o, 1);
      tick(); tick(); tick();
      check("arm_c4_state", state_o, 1);
      tick();
      check("arm_c5_state", state_o, 2);
      check("arm_c5_armed", armed, 0);
      tick();
      check("arm_c6_armed", armed, 1);

      // Exit delay restarts while the door is open
      disarm_req = 1'b1; tick(); disarm_req = 1'b0;
      check("dis_state", state_o, 0);
      arm_req = 1'b1; tick(); arm_req = 1'b0;
      tick();
      door_open = 1'b1; tick(); door_open = 1'b0;
      check("exit_c3_state", state_o, 1);
      tick(); tick(); tick();
      check("exit_c6_state", state_o, 1);
      tick();
      check("exit_c7_state", state_o, 2);

      // Intrusion: entry delay then full siren with flash pattern, then re-arm
      door_open = 1'b1; tick(); door_open = 1'b0;
      for (int c = 1; c <= 13; c++) begin
         if (c <= 3) check("int_entry_state", state_o, 3);
         else if (c <= 11) check("int_alarm_state", state_o, 4);
         else check("int_rearm_state", state_o, 2);
         if (c >= 5 && c <= 12) begin
            check("int_siren_on", siren, 1);
            check("int_flash_pat", lights_flash, pat[c-5]);
         end
         if (c == 13) begin
            check("int_siren_off", siren, 0);
            check("int_flash_off", lights_flash, 0);
         end
         tick();
      end

      // Arm and disarm together in ARMED: disarm wins
      arm_req = 1'b1; disarm_req = 1'b1; tick(); arm_req = 1'b0; disarm_req = 1'b0;
      check("race_state", state_o, 0);

      // Arm request ignored with ignition on
      ignition_on = 1'b1; arm_req = 1'b1; tick(); arm_req = 1'b0; ignition_on = 1'b0;
      check("ign_arm_ignored", state_o, 0);

      // Ignition in ARMED -> ALARM, disarm in ALARM cycle 3
      arm_req = 1'b1; tick(); arm_req = 1'b0;
      repeat (4) tick();
      check("alm2_armed_state", state_o, 2);
      ignition_on = 1'b1; tick(); ignition_on = 1'b0;
      check("alm2_c1_state", state_o, 4);
      tick(); tick();
      disarm_req = 1'b1; tick(); disarm_req = 1'b0;
      check("alm2_dis_state", state_o, 0);
      check("alm2_dis_siren", siren, 1);
      tick();
      check("alm2_siren_off", siren, 0);

      // Asynchronous reset in ALARM cycle 5
      arm_req = 1'b1; tick(); arm_req = 1'b0;
      repeat (4) tick();
      ignition_on = 1'b1; tick(); ignition_on = 1'b0;
      repeat (4) tick();
      check("rst_alm_pre_siren", siren, 1);
      check("rst_alm_pre_state", state_o, 4);
      rst_n = 1'b0;
      #1;
      check("rst_alm_siren", siren, 0);
      check("rst_alm_state", state_o, 0);
      check("rst_alm_flash", lights_flash, 0);
      tick();
      rst_n = 1'b1;

      // Lights-on chime
      lights_on = 1'b1; door_open = 1'b1; tick();
      check("chime_on", lights_warn, 1);
      check("chime_state", state_o, 0);
      ignition_on = 1'b1; tick();
      check("chime_ign_off", lights_warn, 0);
      lights_on = 1'b0; door_open = 1'b0; ignition_on = 1'b0;
      tick();

      // Randomized traffic, including occasional resets
      for (int i = 0; i < 3000; i++) begin
         rst_n       = ($urandom_range(0, 399) != 0);
         arm_req     = ($urandom_range(0, 99) < 15);
         disarm_req  = ($urandom_range(0, 99) < 4);
         door_open   = ($urandom_range(0, 99) < 12);
         ignition_on = ($urandom_range(0, 99) < 5);
         lights_on   = ($urandom_range(0, 1) == 1);
         tick();
      end
      rst_n = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
